spi_flash_slave: RTL
====================

Name: spi_flash_slave

Overview:
Synthesizable single-lane SPI flash responder for mode 0 (CPOL=0, CPHA=0). It is the far end of the SPI master controller's data0/data1/sclk/ss link. All SPI inputs are oversampled in the system clock domain. It holds a byte-addressed memory and serves a subset of the N25Q command set. It stands in for the behavioural flash model in gate-level and FPGA regression tops.

Parameters:
DEPTH, 1024, memory size in bytes; power of two, at least 256
ADDR_W, 24, address width on the wire in bits; the low log2(DEPTH) bits index memory
PAGE, 256, page size in bytes for page-program wrap; power of two, at most DEPTH

Ports:
clk  input  1  system clock; all logic runs on its rising edge
reset  input  1  synchronous, active-high reset
io_spi_ss  input  1  chip select, active low
io_spi_sclk  input  1  SPI clock from master; period at least 8 clk
io_spi_data0  input  1  MOSI
io_spi_data1  output  1  MISO value
io_spi_data1_oe  output  1  MISO drive enable; top-level tri-states data1 when 0
io_busy  output  1  high while ss is low (synchronized)

Behaviour:
- Input sync: ss, sclk and data0 each pass through a 2-flop synchronizer.
  - Rise and fall of sclk are detected on the synced value against a delayed copy.
  - ss falling/rising edges are detected the same way.
- Bit order: MSB first. MOSI is sampled on each sclk rise. MISO updates on each sclk fall, within 3 clk of the raw edge.
- Reset values:
  - io_spi_data1=0, io_spi_data1_oe=0, io_busy=0, WEL=0, state=IDLE.
  - Memory is not cleared by reset; power-on contents are 0xFF.
- ss high at any time:
  - state goes to IDLE; bit and byte counters clear; oe=0 on the next clk.
  - A partial byte is discarded.
  - This overrides any simultaneous sclk edge.
- States:
  - IDLE: wait for ss low, then enter CMD.
  - CMD: shift 8 bits, then decode:
    - 0x03 READ goes to ADDR.
    - 0x02 PP goes to ADDR if WEL=1, else to IGNORE.
    - 0x06 WREN sets WEL; the effect applies at the ss rise, and only if exactly 8 bits were received.
    - 0x04 WRDI clears WEL under the same rule.
    - 0x05 RDSR goes to STATUS.
    - Any other opcode goes to IGNORE.
  - ADDR: shift ADDR_W bits. On the rise that samples the last bit:
    - Latch addr = received value mod DEPTH.
    - READ: load shift register with mem[addr] and go to READ.
    - PP: go to PROG.
  - READ: oe=1. Bit 7 is driven on the first fall after the last address bit. After each 8 bits, addr = (addr+1) mod DEPTH and the next byte loads. Wraps from DEPTH-1 to 0 indefinitely.
  - STATUS: oe=1; shifts out {6'b0, WEL, WIP=0} repeatedly until ss rises.
  - PROG:
    - On each complete received byte: mem[addr] <= mem[addr] & byte (flash AND semantics).
    - The addr low log2(PAGE) bits then increment, wrapping within the page; upper bits are unchanged.
    - At the ss rise, WEL clears if at least one full byte was programmed.
  - IGNORE: oe=0; consume clocks until ss rises.
- oe is 0 in IDLE, CMD, ADDR and PROG; MISO holds its last value when oe=0.
- Reset asserted mid-transaction: abort immediately with the reset values above. Memory writes already committed remain.

Optional Feature:
- Macro: SPI_FLASH_SLAVE_FAST_READ_EN.
- Defined: opcode 0x0B is accepted. After ADDR, a DUMMY state consumes 8 clocks and ignores MOSI. The first data bit is driven on the fall after the 8th dummy rise; it then behaves exactly as READ.
- Undefined: 0x0B decodes as unknown and goes to IGNORE.

Test Plan:
- Power-on then READ 0x03, addr 0x000010, 4 bytes -> MISO returns FF FF FF FF with oe=1 only during data phase.
- WREN (0x06, ss pulse), then PP 0x02 at addr 0x0000FE with bytes A5 3C 0F, then READ from 0x0000FE for 2 bytes and from 0x000000 for 1 byte -> reads A5 3C, then 0F at 0x000000 (page wrap); RDSR afterwards -> 0x00.
- PP without a preceding WREN to addr 0x20 with byte 00 -> READ at 0x20 returns FF; RDSR returns 0x00. WREN then RDSR -> 0x02 repeated on every byte while ss is low.
- READ at addr DEPTH-1 (0x0003FF) for 2 bytes -> byte 0x3FF then byte 0x000. Address 0x000405 on the wire -> reads mem[0x005].
- ss raised after 5 bits of a WREN opcode, or after 12 address bits -> WEL unchanged, state IDLE, oe=0 within 3 clk. Reset pulsed mid-READ -> oe=0 and data1=0 the next cycle.
- With SPI_FLASH_SLAVE_FAST_READ_EN: 0x0B, addr 0x0000FE, one dummy byte -> returns A5 3C. Without the macro, the same sequence -> oe stays 0.

Source files
------------

// File: rtl/spi_flash_slave.sv
`default_nettype none
//==============================================================================
// Module   : spi_flash_slave
// Brief    : Mode-0 SPI flash responder (READ/PP/WREN/WRDI/RDSR) oversampled
//            in clk. Define SPI_FLASH_SLAVE_FAST_READ_EN to accept FAST_READ.
// Revision : 1.0
//==============================================================================
module spi_flash_slave #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 24,
    parameter int PAGE   = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic io_spi_ss,
    input  logic io_spi_sclk,
    input  logic io_spi_data0,
    output logic io_spi_data1,
    output logic io_spi_data1_oe,
    output logic io_busy
);
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(ADDR_W) + 1;
    localparam logic [c_CNT_W-1:0] c_BYTE_LAST = c_CNT_W'(7);
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_W - 1);
    localparam logic [c_AW-1:0]    c_PAGE_MASK = c_AW'(PAGE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_READ   = 3'd3,
        ST_STATUS = 3'd4,
        ST_PROG   = 3'd5,
        ST_IGNORE = 3'd6,
        ST_DUMMY  = 3'd7
    } state_t;

    logic r_ss_meta, r_ss_sync, r_ss_d;
    logic r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic r_d0_meta, r_d0_sync;
    logic w_rise, w_fall;

    state_t r_state, w_state_next;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [2:0]         r_tx_cnt;
    logic [c_AW-2:0]    r_shift;
    logic [c_AW-1:0]    w_shift_next;
    logic [7:0]         w_byte;
    logic [c_AW-1:0]    r_addr, w_rd_addr;
    logic [7:0]         w_rd_data, w_status, r_tx;
    logic r_wel, r_pend_set, r_pend_clr, r_prog_done, r_pp;
    logic r_oe, r_data1, w_oe_next, w_state_chg, w_mem_we;
`ifdef SPI_FLASH_SLAVE_FAST_READ_EN
    logic r_fast;
`endif

    // Stored inverted so that zero power-up contents read back as 0xFF.
    logic [7:0] r_mem_n [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ss_meta   <= 1'b1;
            r_ss_sync   <= 1'b1;
            r_ss_d      <= 1'b1;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_d0_meta   <= 1'b0;
            r_d0_sync   <= 1'b0;
        end else begin
            r_ss_meta   <= io_spi_ss;
            r_ss_sync   <= r_ss_meta;
            r_ss_d      <= r_ss_sync;
            r_sclk_meta <= io_spi_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
            r_d0_meta   <= io_spi_data0;
            r_d0_sync   <= r_d0_meta;
        end
    end

    assign w_rise       = r_sclk_sync & ~r_sclk_d;
    assign w_fall       = ~r_sclk_sync & r_sclk_d;
    assign w_shift_next = {r_shift, r_d0_sync};
    assign w_byte       = w_shift_next[7:0];
    assign w_status     = {6'b0, r_wel, 1'b0};
    assign w_rd_addr    = (r_state == ST_ADDR) ? w_shift_next : r_addr + 1'b1;
    assign w_rd_data    = ~r_mem_n[w_rd_addr];
    assign w_mem_we     = !r_ss_sync && w_rise && (r_state == ST_PROG) &&
                          (r_bit_cnt[2:0] == 3'd7);
    assign w_state_chg  = (w_state_next != r_state);
    assign w_oe_next    = (w_state_next == ST_READ) || (w_state_next == ST_STATUS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_ss_sync) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_CMD;
                ST_CMD: begin
                    if (w_rise && r_bit_cnt == c_BYTE_LAST) begin
                        case (w_byte)
                            8'h03:   w_state_next = ST_ADDR;
                            8'h02:   w_state_next = r_wel ? ST_ADDR : ST_IGNORE;
                            8'h05:   w_state_next = ST_STATUS;
`ifdef SPI_FLASH_SLAVE_FAST_READ_EN
                            8'h0B:   w_state_next = ST_ADDR;
`endif
                            // WREN/WRDI take effect at ss rise; idle until then.
                            default: w_state_next = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (w_rise && r_bit_cnt == c_ADDR_LAST) begin
`ifdef SPI_FLASH_SLAVE_FAST_READ_EN
                        w_state_next = r_pp ? ST_PROG : (r_fast ? ST_DUMMY : ST_READ);
`else
                        w_state_next = r_pp ? ST_PROG : ST_READ;
`endif
                    end
                end
`ifdef SPI_FLASH_SLAVE_FAST_READ_EN
                ST_DUMMY: begin
                    if (w_rise && r_bit_cnt == c_BYTE_LAST) begin
                        w_state_next = ST_READ;
                    end
                end
`endif
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_tx_cnt    <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
            r_tx        <= '0;
            r_wel       <= 1'b0;
            r_pend_set  <= 1'b0;
            r_pend_clr  <= 1'b0;
            r_prog_done <= 1'b0;
            r_pp        <= 1'b0;
            r_oe        <= 1'b0;
            r_data1     <= 1'b0;
`ifdef SPI_FLASH_SLAVE_FAST_READ_EN
            r_fast      <= 1'b0;
`endif
        end else begin
            r_oe <= w_oe_next;
            if (r_ss_sync) begin
                if (!r_ss_d) begin
                    if (r_prog_done || r_pend_clr) begin
                        r_wel <= 1'b0;
                    end else if (r_pend_set) begin
                        r_wel <= 1'b1;
                    end
                end
                r_bit_cnt   <= '0;
                r_tx_cnt    <= '0;
                r_pend_set  <= 1'b0;
                r_pend_clr  <= 1'b0;
                r_prog_done <= 1'b0;
            end else if (w_rise) begin
                r_shift   <= w_shift_next[c_AW-2:0];
                r_bit_cnt <= w_state_chg ? '0 : r_bit_cnt + 1'b1;
                // Any rise after the opcode byte cancels a pending WEL change.
                r_pend_set <= (r_state == ST_CMD) && (r_bit_cnt == c_BYTE_LAST) &&
                              (w_byte == 8'h06);
                r_pend_clr <= (r_state == ST_CMD) && (r_bit_cnt == c_BYTE_LAST) &&
                              (w_byte == 8'h04);
                if (r_state == ST_CMD && r_bit_cnt == c_BYTE_LAST) begin
                    r_pp     <= (w_byte == 8'h02);
`ifdef SPI_FLASH_SLAVE_FAST_READ_EN
                    r_fast   <= (w_byte == 8'h0B);
`endif
                    r_tx     <= w_status;
                    r_tx_cnt <= '0;
                end
                if (r_state == ST_ADDR && r_bit_cnt == c_ADDR_LAST) begin
                    r_addr   <= w_shift_next;
                    r_tx     <= w_rd_data;
                    r_tx_cnt <= '0;
                end
                if (w_mem_we) begin
                    r_addr      <= (r_addr & ~c_PAGE_MASK) | ((r_addr + 1'b1) & c_PAGE_MASK);
                    r_prog_done <= 1'b1;
                end
            end else if (w_fall && (r_state == ST_READ || r_state == ST_STATUS)) begin
                r_data1  <= r_tx[7];
                r_tx_cnt <= r_tx_cnt + 1'b1;
                if (r_tx_cnt == 3'd7) begin
                    if (r_state == ST_STATUS) begin
                        r_tx <= w_status;
                    end else begin
                        r_addr <= w_rd_addr;
                        r_tx   <= w_rd_data;
                    end
                end else begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            r_mem_n[r_addr] <= r_mem_n[r_addr] | ~w_byte;
        end
    end

    assign io_spi_data1    = r_data1;
    assign io_spi_data1_oe = r_oe;
    assign io_busy         = ~r_ss_sync;

endmodule
`default_nettype wire
